axi_mgr_arbiter: RTL

- Round-robin arbiter that shares one AXI subordinate port among `NUM_MGR` single-beat AXI managers, such as the fake CPU instances in the sim client.
- Write and read directions are arbitrated independently.
- Each direction allows exactly one transaction in flight at a time.
- Responses are routed back to the granted manager.
- The block sits between the CPU array and the memory/sim-server bridge.

---
 rtl/axi_pkg.sv | 52 +++++
 rtl/rr_picker.sv | 35 +++
 rtl/axi_mgr_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// AXI single-beat channel payloads and arbiter FSM state encodings
// shared by the manager arbiter and its round-robin picker.
package axi_pkg;

   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 64;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [2:0]                size;
   } axi_aw_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0]   data;
      logic [AXI_DATA_WIDTH/8-1:0] strb;
      logic                        last;
   } axi_w_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
   } axi_b_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [2:0]                size;
   } axi_ar_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic                      last;
   } axi_r_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_AW,
      WR_W,
      WR_B
   } wr_state_e;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_AR,
      RD_R
   } rd_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or above ptr,
// wrapping modulo N.
module rr_picker #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic          req [N],
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   function automatic int wrap_idx(input int p, input int i);
      int s;
      s = p + i;
      return (s >= N) ? s - N : s;
   endfunction

   logic [IW-1:0] idx;

   // Walk downward so the lowest offset from ptr is the last writer.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = IW'(wrap_idx(int'(ptr), i));
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_mgr_arbiter.sv
// Round-robin share of one AXI subordinate among NUM_MGR single-beat
// managers; write and read directions arbitrate independently.
module axi_mgr_arbiter
   import axi_pkg::*;
#(
   parameter int NUM_MGR = 4,
   parameter int IDX_W   = $clog2(NUM_MGR)
) (
   input  logic    clk,
   input  logic    rst_n,
   input  axi_aw_t i_m_aw      [NUM_MGR],
   input  logic    i_m_awvalid [NUM_MGR],
   output logic    o_m_awready [NUM_MGR],
   input  axi_w_t  i_m_w       [NUM_MGR],
   input  logic    i_m_wvalid  [NUM_MGR],
   output logic    o_m_wready  [NUM_MGR],
   output axi_b_t  o_m_b,
   output logic    o_m_bvalid  [NUM_MGR],
   input  logic    i_m_bready  [NUM_MGR],
   input  axi_ar_t i_m_ar      [NUM_MGR],
   input  logic    i_m_arvalid [NUM_MGR],
   output logic    o_m_arready [NUM_MGR],
   output axi_r_t  o_m_r,
   output logic    o_m_rvalid  [NUM_MGR],
   input  logic    i_m_rready  [NUM_MGR],
   output axi_aw_t o_s_aw,
   output logic    o_s_awvalid,
   input  logic    i_s_awready,
   output axi_w_t  o_s_w,
   output logic    o_s_wvalid,
   input  logic    i_s_wready,
   input  axi_b_t  i_s_b,
   input  logic    i_s_bvalid,
   output logic    o_s_bready,
   output axi_ar_t o_s_ar,
   output logic    o_s_arvalid,
   input  logic    i_s_arready,
   input  axi_r_t  i_s_r,
   input  logic    i_s_rvalid,
   output logic    o_s_rready,
   output logic    o_err_id
);

   wr_state_e        wr_state_q, wr_state_d;
   rd_state_e        rd_state_q, rd_state_d;
   logic [IDX_W-1:0] wr_gnt_q, wr_gnt_d;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0] rd_gnt_q, rd_gnt_d;
   logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             err_q, err_d;
   logic             wr_bad, rd_bad;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             wr_vld, rd_vld;

   function automatic logic [IDX_W-1:0] nxt_ptr(input logic [IDX_W-1:0] g);
      return (g == IDX_W'(NUM_MGR - 1)) ? '0 : g + IDX_W'(1);
   endfunction

   rr_picker #(.N(NUM_MGR)) u_wr_pick (
      .req     (i_m_awvalid),
      .ptr     (wr_ptr_q),
      .gnt_idx (wr_idx),
      .gnt_vld (wr_vld)
   );

   rr_picker #(.N(NUM_MGR)) u_rd_pick (
      .req     (i_m_arvalid),
      .ptr     (rd_ptr_q),
      .gnt_idx (rd_idx),
      .gnt_vld (rd_vld)
   );

   always_comb begin
      wr_state_d  = wr_state_q;
      wr_gnt_d    = wr_gnt_q;
      wr_ptr_d    = wr_ptr_q;
      wr_bad      = 1'b0;
      o_s_aw      = '0;
      o_s_awvalid = 1'b0;
      o_s_w       = '0;
      o_s_wvalid  = 1'b0;
      o_m_b       = '0;
      o_s_bready  = 1'b0;
      for (int i = 0; i < NUM_MGR; i++) begin
         o_m_awready[i] = 1'b0;
         o_m_wready[i]  = 1'b0;
         o_m_bvalid[i]  = 1'b0;
      end
      unique case (wr_state_q)
         WR_IDLE: begin
            if (wr_vld) begin
               wr_gnt_d   = wr_idx;
               wr_state_d = WR_AW;
            end
         end
         WR_AW: begin
            o_s_aw                = i_m_aw[wr_gnt_q];
            o_s_awvalid           = i_m_awvalid[wr_gnt_q];
            o_m_awready[wr_gnt_q] = i_s_awready;
            if (i_m_awvalid[wr_gnt_q] && i_s_awready) wr_state_d = WR_W;
         end
         WR_W: begin
            o_s_w                = i_m_w[wr_gnt_q];
            o_s_wvalid           = i_m_wvalid[wr_gnt_q];
            o_m_wready[wr_gnt_q] = i_s_wready;
            if (i_m_wvalid[wr_gnt_q] && i_s_wready) wr_state_d = WR_B;
         end
         WR_B: begin
            o_m_b                = i_s_b;
            o_m_bvalid[wr_gnt_q] = i_s_bvalid;
            o_s_bready           = i_m_bready[wr_gnt_q];
            if (i_s_bvalid && i_m_bready[wr_gnt_q]) begin
               wr_bad     = i_s_b.id != AXI_ID_WIDTH'(wr_gnt_q);
               wr_ptr_d   = nxt_ptr(wr_gnt_q);
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d  = rd_state_q;
      rd_gnt_d    = rd_gnt_q;
      rd_ptr_d    = rd_ptr_q;
      rd_bad      = 1'b0;
      o_s_ar      = '0;
      o_s_arvalid = 1'b0;
      o_m_r       = '0;
      o_s_rready  = 1'b0;
      for (int i = 0; i < NUM_MGR; i++) begin
         o_m_arready[i] = 1'b0;
         o_m_rvalid[i]  = 1'b0;
      end
      unique case (rd_state_q)
         RD_IDLE: begin
            if (rd_vld) begin
               rd_gnt_d   = rd_idx;
               rd_state_d = RD_AR;
            end
         end
         RD_AR: begin
            o_s_ar                = i_m_ar[rd_gnt_q];
            o_s_arvalid           = i_m_arvalid[rd_gnt_q];
            o_m_arready[rd_gnt_q] = i_s_arready;
            if (i_m_arvalid[rd_gnt_q] && i_s_arready) rd_state_d = RD_R;
         end
         RD_R: begin
            o_m_r                = i_s_r;
            o_m_rvalid[rd_gnt_q] = i_s_rvalid;
            o_s_rready           = i_m_rready[rd_gnt_q];
            if (i_s_rvalid && i_m_rready[rd_gnt_q]) begin
               rd_bad     = i_s_r.id != AXI_ID_WIDTH'(rd_gnt_q);
               rd_ptr_d   = nxt_ptr(rd_gnt_q);
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Misrouted IDs are recorded but the response still goes to the grantee.
   assign err_d    = err_q | wr_bad | rd_bad;
   assign o_err_id = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
         wr_gnt_q   <= '0;
         wr_ptr_q   <= '0;
         rd_gnt_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_gnt_q   <= wr_gnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_gnt_q   <= rd_gnt_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
      end
   end

endmodule
